multicycle_control: RTL



---
 rtl/multicycle_control_if.sv | 60 ++++++
 rtl/multicycle_control.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_if
// Bundles the decode inputs and every datapath control output of the SCPU
// multi-cycle control FSM.
//
// Modports:
//   master : the control FSM (reads opcode/funct/zero, drives the controls)
//   slave  : the datapath (drives opcode/funct/zero, reads the controls)
//
// Signals:
//   opcode, funct      IR[31:26] / IR[5:0]
//   zero               ALU zero flag, combinational in the current cycle
//   pc_we .. ben       register enables
//   mem_we, reg_we     memory / regfile write enables
//   memin, regin       memory address select / writeback data select
//   dst                write register select (rd / rt / r31)
//   alusrca, alusrcb   ALU operand selects
//   pcsrc              PC source select
//   bneBEQ             0 = beq, 1 = bne
//   aluOps             ALU command (ADD/SUB/XOR/SLT)
//   state              current FSM state, for debug
//   halted             set while parked in HALT (trap build only)
// -----------------------------------------------------------------------------
interface multicycle_control_if #(
  parameter int OP_W = 6,
  parameter int ST_W = 4
);
  logic [OP_W-1:0] opcode;
  logic [OP_W-1:0] funct;
  logic            zero;
  logic            pc_we;
  logic            ir_we;
  logic            a_we;
  logic            b_we;
  logic            ben;
  logic            mem_we;
  logic            reg_we;
  logic            memin;
  logic            regin;
  logic [1:0]      dst;
  logic [1:0]      alusrca;
  logic [1:0]      alusrcb;
  logic [1:0]      pcsrc;
  logic            bneBEQ;
  logic [2:0]      aluOps;
  logic [ST_W-1:0] state;
  logic            halted;

  modport master (
    input  opcode, funct, zero,
    output pc_we, ir_we, a_we, b_we, ben, mem_we, reg_we, memin, regin,
           dst, alusrca, alusrcb, pcsrc, bneBEQ, aluOps, state, halted
  );

  modport slave (
    output opcode, funct, zero,
    input  pc_we, ir_we, a_we, b_we, ben, mem_we, reg_we, memin, regin,
           dst, alusrca, alusrcb, pcsrc, bneBEQ, aluOps, state, halted
  );
endinterface

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Control FSM for the SCPU multi-cycle datapath. Sequences FETCH / DECODE /
// EXEC / MEM / WB for LW, SW, J, JAL, JR, BEQ, BNE, ADDI, XORI, ADD, SUB, SLT
// and drives every enable, select and ALU command of the datapath each cycle.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous, active-low reset
//   bus    multicycle_control_if.master (decode inputs + all control outputs)
//
// Optional build macro:
//   ILLEGAL_TRAP_EN  illegal instructions park the FSM in HALT (halted = 1)
//                    until reset; without it they execute as a 3-cycle NOP.
//
// Outputs are a decode of the state register, gated by reset so that every
// enable and select drops the instant reset falls. pc_we in BRANCH follows
// the live zero flag, so the decode is deliberately combinational.
// -----------------------------------------------------------------------------
module multicycle_control #(
  parameter int OP_W = 6,
  parameter int ST_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  // State encodings. All sixteen 4-bit codes are used; in the trap build HALT
  // shares the ILLEGAL code and is told apart by r_halted.
  localparam logic [ST_W-1:0] S_FETCH    = ST_W'(4'd0);
  localparam logic [ST_W-1:0] S_DECODE   = ST_W'(4'd1);
  localparam logic [ST_W-1:0] S_EXEC_R   = ST_W'(4'd2);
  localparam logic [ST_W-1:0] S_R_WB     = ST_W'(4'd3);
  localparam logic [ST_W-1:0] S_EXEC_I   = ST_W'(4'd4);
  localparam logic [ST_W-1:0] S_I_WB     = ST_W'(4'd5);
  localparam logic [ST_W-1:0] S_MEM_ADDR = ST_W'(4'd6);
  localparam logic [ST_W-1:0] S_MEM_RD   = ST_W'(4'd7);
  localparam logic [ST_W-1:0] S_MEM_WB   = ST_W'(4'd8);
  localparam logic [ST_W-1:0] S_MEM_WR   = ST_W'(4'd9);
  localparam logic [ST_W-1:0] S_BRANCH   = ST_W'(4'd10);
  localparam logic [ST_W-1:0] S_JUMP     = ST_W'(4'd11);
  localparam logic [ST_W-1:0] S_JAL      = ST_W'(4'd12);
  localparam logic [ST_W-1:0] S_JAL_WB   = ST_W'(4'd13);
  localparam logic [ST_W-1:0] S_JR       = ST_W'(4'd14);
  localparam logic [ST_W-1:0] S_ILLEGAL  = ST_W'(4'd15);

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'h00);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'h02);
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'(6'h03);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'h04);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'h05);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'h08);
  localparam logic [OP_W-1:0] OP_XORI  = OP_W'(6'h0E);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'h23);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'h2B);

  localparam logic [OP_W-1:0] FN_JR  = OP_W'(6'h08);
  localparam logic [OP_W-1:0] FN_ADD = OP_W'(6'h20);
  localparam logic [OP_W-1:0] FN_SUB = OP_W'(6'h22);
  localparam logic [OP_W-1:0] FN_SLT = OP_W'(6'h2A);

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;

  logic [ST_W-1:0] r_state;
  logic [ST_W-1:0] w_next_state;

  logic       w_pc_we, w_ir_we, w_a_we, w_b_we, w_ben;
  logic       w_mem_we, w_reg_we, w_memin, w_regin, w_bne;
  logic [1:0] w_dst, w_alusrca, w_alusrcb, w_pcsrc;
  logic [2:0] w_aluops;

  // DECODE dispatch: maps the latched opcode/funct onto the first execute state.
  function automatic logic [ST_W-1:0] decode_dispatch(
    input logic [OP_W-1:0] op,
    input logic [OP_W-1:0] fn
  );
    logic [ST_W-1:0] nxt;
    nxt = S_ILLEGAL;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_SUB, FN_SLT: nxt = S_EXEC_R;
          FN_JR:                  nxt = S_JR;
          default:                nxt = S_ILLEGAL;
        endcase
      end
      OP_LW, OP_SW:     nxt = S_MEM_ADDR;
      OP_ADDI, OP_XORI: nxt = S_EXEC_I;
      OP_BEQ, OP_BNE:   nxt = S_BRANCH;
      OP_J:             nxt = S_JUMP;
      OP_JAL:           nxt = S_JAL;
      default:          nxt = S_ILLEGAL;
    endcase
    return nxt;
  endfunction

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; unreachable codes fall back to FETCH.
  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH:    w_next_state = S_DECODE;
      S_DECODE:   w_next_state = decode_dispatch(bus.opcode, bus.funct);
      S_EXEC_R:   w_next_state = S_R_WB;
      S_EXEC_I:   w_next_state = S_I_WB;
      S_MEM_ADDR: begin
        if (bus.opcode == OP_LW) begin
          w_next_state = S_MEM_RD;
        end else begin
          w_next_state = S_MEM_WR;
        end
      end
      S_MEM_RD:   w_next_state = S_MEM_WB;
      S_JAL:      w_next_state = S_JAL_WB;
`ifdef ILLEGAL_TRAP_EN
      S_ILLEGAL:  w_next_state = S_ILLEGAL;
`else
      S_ILLEGAL:  w_next_state = S_FETCH;
`endif
      S_R_WB, S_I_WB, S_MEM_WB, S_MEM_WR,
      S_BRANCH, S_JUMP, S_JAL_WB, S_JR:
                  w_next_state = S_FETCH;
      default:    w_next_state = S_FETCH;
    endcase
  end

  // Control decode: every output not named for a state stays 0.
  always_comb begin
    w_pc_we   = 1'b0;
    w_ir_we   = 1'b0;
    w_a_we    = 1'b0;
    w_b_we    = 1'b0;
    w_ben     = 1'b0;
    w_mem_we  = 1'b0;
    w_reg_we  = 1'b0;
    w_memin   = 1'b0;
    w_regin   = 1'b0;
    w_dst     = 2'd0;
    w_alusrca = 2'd0;
    w_alusrcb = 2'd0;
    w_pcsrc   = 2'd0;
    w_bne     = 1'b0;
    w_aluops  = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_ir_we   = 1'b1;
        w_alusrcb = 2'd3;
        w_pcsrc   = 2'd2;
        w_pc_we   = 1'b1;
      end
      S_DECODE: begin
        // PC + shifted imm lands in alu_reg as the branch target.
        w_a_we = 1'b1;
        w_b_we = 1'b1;
      end
      S_EXEC_R: begin
        w_alusrca = 2'd1;
        w_alusrcb = 2'd2;
        case (bus.funct)
          FN_SUB:  w_aluops = ALU_SUB;
          FN_SLT:  w_aluops = ALU_SLT;
          default: w_aluops = ALU_ADD;
        endcase
      end
      S_R_WB: begin
        w_regin  = 1'b1;
        w_reg_we = 1'b1;
      end
      S_EXEC_I: begin
        w_alusrca = 2'd1;
        w_alusrcb = 2'd1;
        if (bus.opcode == OP_XORI) begin
          w_aluops = ALU_XOR;
        end else begin
          w_aluops = ALU_ADD;
        end
      end
      S_I_WB, S_JAL_WB: begin
        w_dst    = (r_state == S_JAL_WB) ? 2'd2 : 2'd1;
        w_regin  = 1'b1;
        w_reg_we = 1'b1;
      end
      S_MEM_ADDR: begin
        w_alusrca = 2'd1;
        w_alusrcb = 2'd1;
      end
      S_MEM_RD: w_memin = 1'b1;
      S_MEM_WB: begin
        w_dst    = 2'd1;
        w_reg_we = 1'b1;
      end
      S_MEM_WR: begin
        w_memin  = 1'b1;
        w_mem_we = 1'b1;
      end
      S_BRANCH: begin
        // opcode[0] distinguishes BNE from BEQ; taken when zero disagrees with it.
        w_alusrca = 2'd1;
        w_alusrcb = 2'd2;
        w_aluops  = ALU_SUB;
        w_bne     = bus.opcode[0];
        w_pcsrc   = 2'd3;
        w_pc_we   = bus.zero ^ bus.opcode[0];
      end
      S_JUMP: begin
        w_pcsrc = 2'd1;
        w_pc_we = 1'b1;
      end
      S_JAL: begin
        // PC already holds JAL+4; one more +4 gives the JAL+8 link value.
        w_pcsrc   = 2'd1;
        w_pc_we   = 1'b1;
        w_alusrcb = 2'd3;
      end
      S_JR: begin
        // rt is r0 by encoding, so A + B is just rs.
        w_alusrca = 2'd1;
        w_alusrcb = 2'd2;
        w_pcsrc   = 2'd2;
        w_pc_we   = 1'b1;
      end
      default: begin
        w_pc_we = 1'b0;
      end
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  logic r_halted;

  // HALT flag: set on leaving the ILLEGAL cycle, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_halted <= 1'b0;
    end else if (r_state == S_ILLEGAL) begin
      r_halted <= 1'b1;
    end else begin
      r_halted <= r_halted;
    end
  end

  assign bus.halted = reset & r_halted;
`else
  assign bus.halted = 1'b0;
`endif

  // Reset gates every control asynchronously so no write survives its falling edge.
  assign bus.pc_we   = reset & w_pc_we;
  assign bus.ir_we   = reset & w_ir_we;
  assign bus.a_we    = reset & w_a_we;
  assign bus.b_we    = reset & w_b_we;
  assign bus.ben     = reset & w_ben;
  assign bus.mem_we  = reset & w_mem_we;
  assign bus.reg_we  = reset & w_reg_we;
  assign bus.memin   = reset & w_memin;
  assign bus.regin   = reset & w_regin;
  assign bus.bneBEQ  = reset & w_bne;
  assign bus.dst     = reset ? w_dst     : 2'd0;
  assign bus.alusrca = reset ? w_alusrca : 2'd0;
  assign bus.alusrcb = reset ? w_alusrcb : 2'd0;
  assign bus.pcsrc   = reset ? w_pcsrc   : 2'd0;
  assign bus.aluOps  = reset ? w_aluops  : 3'd0;
  assign bus.state   = r_state;

endmodule
